// File: rtl/ff_video_pkg.sv
// Shared video constants and the sync/blank pipeline bundle
// used by the Food Fight scan doubler.
package ff_video_pkg;

  localparam int FF_H_TOTAL  = 384;
  localparam int FF_H_ACTIVE = 256;
  localparam int FF_PIX_W    = 8;
  localparam int FF_HS_WIDTH = 46;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } ctl_t;

endpackage

// File: rtl/ff_line_buffer.sv
// Ping-pong line store: one write port, one synchronous
// write-first read port, both on clk12m.
module ff_line_buffer
  import ff_video_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                clk12m,
  input  logic                we,
  input  logic [ADDR_W:0]     waddr,
  input  logic [FF_PIX_W-1:0] wdata,
  input  logic [ADDR_W:0]     raddr,
  output logic [FF_PIX_W-1:0] rdata
);

  logic [FF_PIX_W-1:0] mem [2**(ADDR_W+1)];

  // Write port
  always_ff @(posedge clk12m) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read, returning fresh data on a same-address write
  always_ff @(posedge clk12m) begin
    if (we && (waddr == raddr)) rdata <= wdata;
    else rdata <= mem[raddr];
  end

endmodule

// File: rtl/ff_scandoubler.sv
// Captures each 15 kHz arcade line and replays it twice at
// the 12 MHz rate to produce a 31 kHz VGA stream.
module ff_scandoubler
  import ff_video_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int HS_WIDTH = FF_HS_WIDTH,
  parameter int CNT_W    = 11
) (
  input  logic                clk12m,
  input  logic                reset_n,
  input  logic                pix_ce,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                blank_i,
  input  logic [FF_PIX_W-1:0] rgb_i,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                blank_o,
  output logic [FF_PIX_W-1:0] rgb_o,
  output logic                locked
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              hs_q;
  logic              wbank;
  logic [ADDR_W:0]   wr_cnt;
  logic [CNT_W-1:0]  h_in;
  logic [CNT_W-1:0]  cur_start;
  logic [CNT_W-1:0]  cur_len;
  logic [CNT_W-1:0]  h_start;
  logic [CNT_W-1:0]  act_len;
  logic              vs_line;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  out_len;
  logic              seen;
  logic [CNT_W-1:0]  h_out;
  logic              copy;
  ctl_t              ctl_q;
  logic [FF_PIX_W-1:0] rdata;

  logic              hs_edge;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  len;
  logic [ADDR_W:0]   wcnt;
  logic              wb;
  logic              we;
  logic [ADDR_W-1:0] off;
  logic [CNT_W:0]    a_end;
  logic              act;

  // An edge restarts the line in the same pixel it is seen
  assign hs_edge = pix_ce & hs_q & ~hsync_i;
  assign idx     = hs_edge ? '0 : h_in;
  assign len     = hs_edge ? '0 : cur_len;
  assign wcnt    = hs_edge ? '0 : wr_cnt;
  assign wb      = wbank ^ hs_edge;
  assign we      = pix_ce & ~blank_i & ~wcnt[ADDR_W];

  assign off   = ADDR_W'(h_out - h_start);
  assign a_end = {1'b0, h_start} + {1'b0, act_len};
  assign act   = locked && (h_out >= h_start)
              && ({1'b0, h_out} < a_end);

  ff_line_buffer #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk12m (clk12m),
    .we     (we),
    .waddr  ({wb, wcnt[ADDR_W-1:0]}),
    .wdata  (rgb_i),
    .raddr  ({~wbank, off}),
    .rdata  (rdata)
  );

  // Capture side: line geometry and buffer write pointer
  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      hs_q      <= 1'b1;
      wbank     <= 1'b0;
      wr_cnt    <= '0;
      h_in      <= '0;
      cur_start <= '0;
      cur_len   <= '0;
      h_start   <= '0;
      act_len   <= '0;
      vs_line   <= 1'b1;
    end else if (pix_ce) begin
      hs_q <= hsync_i;
      if (hs_edge) begin
        wbank   <= ~wbank;
        h_start <= cur_start;
        act_len <= cur_len;
        vs_line <= vsync_i;
      end
      h_in   <= (idx == CMAX) ? idx : idx + 1'b1;
      wr_cnt <= wcnt + (ADDR_W+1)'(we);
      if (!blank_i) begin
        if (len == '0) cur_start <= idx;
        cur_len <= (len == CMAX) ? len : len + 1'b1;
      end else begin
        cur_len <= len;
      end
    end
  end

  // Line period measurement and lock decision
  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      per_cnt <= '0;
      out_len <= '0;
      seen    <= 1'b0;
      locked  <= 1'b0;
    end else begin
      if (hs_edge) per_cnt <= CNT_W'(1);
      else if (per_cnt != CMAX) per_cnt <= per_cnt + 1'b1;
      if (hs_edge) begin
        seen    <= 1'b1;
        out_len <= per_cnt >> 1;
        locked  <= seen && (per_cnt != CMAX)
                && ((per_cnt >> 1) >= CNT_W'(16));
      end
    end
  end

  // Output position: first copy wraps once, second runs to the edge
  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      h_out <= '0;
      copy  <= 1'b0;
    end else if (hs_edge) begin
      h_out <= '0;
      copy  <= 1'b0;
    end else if (!copy && (h_out == out_len - 1'b1)) begin
      h_out <= '0;
      copy  <= 1'b1;
    end else if (h_out != CMAX) begin
      h_out <= h_out + 1'b1;
    end
  end

  // Sync/active stage aligned with the RAM read latency
  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      ctl_q <= '{hs: 1'b1, vs: 1'b1, act: 1'b0};
    end else begin
      ctl_q.hs  <= ~(locked && (h_out < CNT_W'(HS_WIDTH)));
      ctl_q.vs  <= ~locked | vs_line;
      ctl_q.act <= act;
    end
  end

  // Registered VGA outputs
  always_ff @(posedge clk12m) begin
    if (!reset_n) begin
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      blank_o <= 1'b1;
      rgb_o   <= '0;
    end else begin
      hsync_o <= ctl_q.hs;
      vsync_o <= ctl_q.vs;
      blank_o <= ~ctl_q.act;
      rgb_o   <= ctl_q.act ? rdata : '0;
    end
  end

endmodule
